red_pitaya_pwm_capture: RTL and testbench
=========================================

# red_pitaya_pwm_capture

Four-channel capture for the slow-DAC PWM outputs. It measures the high time of each PWM period and the 16-period frame sum. The result recovers the full-resolution 8.4 duty value the PWM generator encodes (8-bit base plus dithered fractional bits). The block sits on the 2x DAC clock next to the analog interface and supports loopback self-test and output monitoring of the PWM pins.

## Interface
Parameters:
- PWM_FULL, 156: period length in clocks; must match the generator.
- DLY, 7: clocks from the `sync_i` pulse to the first window cycle of a frame at the synchronizer output.

Ports (single clock; reset is asynchronous and active-low):
- clk_i  in  1  2x DAC clock (250 MHz).
- rstn_i  in  1  asynchronous active-low reset.
- pwm_i  in  4  PWM pins, asynchronous; bit n is channel n.
- sync_i  in  1  generator sync pulse, synchronous to clk_i, one clock wide.
- clr_i  in  1  clears `sync_err_o`.
- per_dat_o  out  4x8  last period high count per channel; channel n in bits [8n+7:8n].
- per_vld_o  out  1  one-clock pulse when `per_dat_o` updates.
- frm_dat_o  out  4x12  last frame sum per channel; channel n in bits [12n+11:12n].
- frm_vld_o  out  1  one-clock pulse when `frm_dat_o` updates.
- locked_o  out  1  framing established.
- sync_err_o  out  1  sticky misalignment flag.

## Operation
- `pwm_i` passes through a 2-flop synchronizer per bit. Only the synchronized value is used below.
- `sync_i` feeds a DLY-deep shift register, whose output is called `sev`.
- Window counter `pos` counts 1..PWM_FULL and wraps to 1. Frame counter `frm` counts 0..15 and increments when `pos` wraps.
- State machine:
  - HUNT: counters are held and no valid pulses are issued. On `sev`: set pos=1 and frm=0, clear the accumulators, then go to LOCK.
  - LOCK: the counters free-run.
    - `sev` with pos==PWM_FULL and frm==15 is the expected alignment. No action is taken.
    - `sev` at any other position: set `sync_err_o`, reload pos=1 and frm=0, and discard the partial frame (no `frm_vld_o` for it).
- Per channel, when pos==1 the high counter restarts at the sample value (0/1). Otherwise it adds the sample.
- At pos==PWM_FULL (period end):
  - The high counter, including the current sample, is written to `per_dat_o`, and `per_vld_o` pulses.
  - The frame accumulator adds the high count. When frm==15 the accumulator total goes to `frm_dat_o`, `frm_vld_o` pulses, and the accumulator clears.
- Widths and value ranges:
  - The high count is at most PWM_FULL (8 bits, no saturation needed).
  - The frame sum is at most 16*156 = 2496 (12 bits).
  - For generator input {va[7:0], ba[15:0]} with va < 156: `frm_dat_o` = 16*va + popcount(ba).
- `clr_i` clears `sync_err_o`. If `clr_i` and an error event occur in the same clock, the error wins.

## Timing
- Reset values: all outputs 0, state HUNT, counters 0, shift register 0.
- Synchronizer latency is 2 clocks. DLY=7 covers the generator sync-to-wrap time (2), the generator output pipeline (3) and the synchronizer (2).
- `per_vld_o` and `frm_vld_o` are registered. They pulse in the clock after the period-end cycle, together with the new data. `frm_vld_o` coincides with the `per_vld_o` of period 15.
- `locked_o` rises in the clock after the first `sev`. The first `frm_vld_o` arrives 16*PWM_FULL+1 clocks after that `sev`.
- Reset mid-frame discards all state. A new frame requires a fresh `sync_i`.
- `sev` arriving in HUNT on the same clock as `clr_i` simply locks.

## Structure
- Package `red_pitaya_pwm_pkg` holds:
  - PWM_FULL_DEF = 156 and FRAME_LEN = 16;
  - width constants PER_W = 8 and FRM_W = 12;
  - the HUNT/LOCK state enum.
- Sub-module `red_pitaya_pwm_cap_ch`, instantiated 4 times, contains the synchronizer, high counter and frame accumulator for one channel.
- The top level owns the delay line, `pos` and `frm`, and the state machine.

## Test plan
- Generator loopback with a = 24'h400000, repeated `sync_i` -> `per_dat_o[7:0]` = 64 every period, `frm_dat_o[11:0]` = 1024, `sync_err_o` = 0.
- a = 24'h400003 -> periods 0 and 1 give 65, periods 2-15 give 64, frame sum 1026. b = 24'h40FFFF -> 65 every period, frame sum 1040.
- c = 24'h9C0000 -> pin constantly high, per 156, frame 2496. d = 24'h000000 -> per 0, frame 0.
- Shift one `sync_i` pulse by +5 clocks -> `sync_err_o` = 1 and one frame produces no `frm_vld_o`. The next frame is correct. `clr_i` then returns `sync_err_o` to 0.
- Deassert `rstn_i` in period 8 -> all outputs 0 immediately and `locked_o` = 0. After release, no valid pulses occur until the next `sync_i`. The first frame is exact.

Source files
------------

// File: rtl/red_pitaya_pwm_pkg.sv
// Shared constants and state encoding for the slow-DAC PWM capture block.
package red_pitaya_pwm_pkg;

    localparam int PWM_FULL_DEF = 156;
    localparam int FRAME_LEN    = 16;
    localparam int PER_W        = 8;
    localparam int FRM_W        = 12;
    localparam int N_CH         = 4;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/red_pitaya_pwm_cap_ch.sv
// One capture channel: pin synchronizer, per-period high counter and frame accumulator.
module red_pitaya_pwm_cap_ch
    import red_pitaya_pwm_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             pwm_i,
    input  logic             en_i,
    input  logic             first_i,
    input  logic             last_i,
    input  logic             frame_end_i,
    input  logic             acc_clr_i,
    output logic [PER_W-1:0] per_o,
    output logic [FRM_W-1:0] frm_o
);

    logic [1:0]       sync_q;
    logic             sample;
    logic [PER_W-1:0] high;
    logic [FRM_W-1:0] sum;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [FRM_W-1:0] acc_q, acc_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [FRM_W-1:0] frm_q, frm_d;

    always_comb begin
        sample = sync_q[1];
        // high includes the current sample, so the period-end cycle reports the full count
        high   = first_i ? PER_W'(sample) : cnt_q + PER_W'(sample);
        sum    = acc_q + FRM_W'(high);
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        per_d  = per_q;
        frm_d  = frm_q;
        if (en_i) begin
            cnt_d = high;
            if (last_i) begin
                per_d = high;
                if (frame_end_i) begin
                    frm_d = sum;
                    acc_d = '0;
                end else begin
                    acc_d = sum;
                end
            end
        end
        if (acc_clr_i) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            per_q  <= '0;
            frm_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], pwm_i};
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            per_q  <= per_d;
            frm_q  <= frm_d;
        end
    end

    assign per_o = per_q;
    assign frm_o = frm_q;

endmodule

// File: rtl/red_pitaya_pwm_capture.sv
// Four-channel PWM capture: sync delay line, period/frame window counters and HUNT/LOCK framing.
module red_pitaya_pwm_capture
    import red_pitaya_pwm_pkg::*;
#(
    parameter int PWM_FULL = PWM_FULL_DEF,
    parameter int DLY      = 7
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [N_CH-1:0]         pwm_i,
    input  logic                    sync_i,
    input  logic                    clr_i,
    output logic [N_CH*PER_W-1:0]   per_dat_o,
    output logic                    per_vld_o,
    output logic [N_CH*FRM_W-1:0]   frm_dat_o,
    output logic                    frm_vld_o,
    output logic                    locked_o,
    output logic                    sync_err_o
);

    localparam int POS_W  = $clog2(PWM_FULL + 1);
    localparam int FCNT_W = $clog2(FRAME_LEN);
    localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(PWM_FULL);
    localparam logic [FCNT_W-1:0] FRM_LAST = FCNT_W'(FRAME_LEN - 1);

    state_e              state_q, state_d;
    logic [DLY-1:0]      sr_q, sr_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [FCNT_W-1:0]   frm_q, frm_d;
    logic                err_q, err_d;
    logic                per_vld_q, frm_vld_q;
    logic                sev, err_set, acc_clr;
    logic                locked, period_end, frame_end;

    always_comb begin
        sr_d       = {sr_q[DLY-2:0], sync_i};
        sev        = sr_q[DLY-1];
        state_d    = state_q;
        pos_d      = pos_q;
        frm_d      = frm_q;
        err_set    = 1'b0;
        acc_clr    = 1'b0;
        locked     = (state_q == ST_LOCK);
        period_end = locked && (pos_q == POS_LAST);
        frame_end  = period_end && (frm_q == FRM_LAST);
        case (state_q)
            ST_HUNT: begin
                if (sev) begin
                    state_d = ST_LOCK;
                    pos_d   = POS_ONE;
                    frm_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            default: begin
                if (pos_q == POS_LAST) begin
                    pos_d = POS_ONE;
                    frm_d = (frm_q == FRM_LAST) ? '0 : frm_q + 1'b1;
                end else begin
                    pos_d = pos_q + 1'b1;
                end
                // a sync landing anywhere but the frame wrap re-frames and drops the partial frame
                if (sev && !frame_end) begin
                    err_set = 1'b1;
                    pos_d   = POS_ONE;
                    frm_d   = '0;
                    acc_clr = 1'b1;
                end
            end
        endcase
        err_d = err_set ? 1'b1 : (clr_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_HUNT;
            sr_q      <= '0;
            pos_q     <= '0;
            frm_q     <= '0;
            err_q     <= 1'b0;
            per_vld_q <= 1'b0;
            frm_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            pos_q     <= pos_d;
            frm_q     <= frm_d;
            err_q     <= err_d;
            per_vld_q <= period_end;
            frm_vld_q <= frame_end;
        end
    end

    for (genvar n = 0; n < N_CH; n++) begin : g_ch
        red_pitaya_pwm_cap_ch u_ch (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .pwm_i       (pwm_i[n]),
            .en_i        (locked),
            .first_i     (pos_q == POS_ONE),
            .last_i      (pos_q == POS_LAST),
            .frame_end_i (frame_end),
            .acc_clr_i   (acc_clr),
            .per_o       (per_dat_o[n*PER_W +: PER_W]),
            .frm_o       (frm_dat_o[n*FRM_W +: FRM_W])
        );
    end

    assign per_vld_o  = per_vld_q;
    assign frm_vld_o  = frm_vld_q;
    assign locked_o   = (state_q == ST_LOCK);
    assign sync_err_o = err_q;

endmodule

// File: tb/tb_red_pitaya_pwm_capture.sv
// Loopback bench: models the PWM generator per frame, predicts period/frame results into queues.
module tb_red_pitaya_pwm_capture;

    localparam int PWM_FULL = 156;
    localparam int DLY      = 7;
    localparam int FL       = 16 * PWM_FULL;
    localparam int NF       = 12;
    localparam int T0       = 20;
    localparam int F_SHIFT  = 7;
    localparam int F_RST    = 9;
    localparam int T_END    = T0 + NF * FL + 20;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  pwm;
    logic        sync;
    logic        clr;
    logic [31:0] per_dat;
    logic        per_vld;
    logic [47:0] frm_dat;
    logic        frm_vld;
    logic        locked;
    logic        sync_err;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [23:0] fa [NF][4];
    int          fshift [NF];
    logic [31:0] per_q[$];
    logic [47:0] frm_q[$];

    always #2 clk = ~clk;

    red_pitaya_pwm_capture #(.PWM_FULL(PWM_FULL), .DLY(DLY)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .pwm_i      (pwm),
        .sync_i     (sync),
        .clr_i      (clr),
        .per_dat_o  (per_dat),
        .per_vld_o  (per_vld),
        .frm_dat_o  (frm_dat),
        .frm_vld_o  (frm_vld),
        .locked_o   (locked),
        .sync_err_o (sync_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int s_of(int f);
        return T0 + f * FL;
    endfunction

    // generator encoding: period p is high for va + ba[p] clocks
    function automatic int hi_of(logic [23:0] a, int p);
        return int'(a[23:16]) + int'(a[p]);
    endfunction

    // first counted window sample is the pin value DLY-1 clocks after sync
    function automatic logic [3:0] pins_at(int t);
        logic [3:0] v;
        int j, f, k, p, c;
        v = '0;
        j = t - T0 - (DLY - 1);
        if (j >= 0 && j < NF * FL) begin
            f = j / FL;
            k = j % FL;
            p = k / PWM_FULL;
            c = k % PWM_FULL;
            for (int ch = 0; ch < 4; ch++) v[ch] = (c < hi_of(fa[f][ch], p));
        end
        return v;
    endfunction

    function automatic logic is_sync(int t);
        for (int f = 0; f < NF; f++) if (t == s_of(f) + fshift[f]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic build_plan();
        logic [23:0] dir [6];
        logic [31:0] pw;
        logic [47:0] fw;
        int nper;
        dir = '{24'h400000, 24'h400000, 24'h400003, 24'h40FFFF, 24'h9C0000, 24'h000000};
        for (int f = 0; f < NF; f++) begin
            fshift[f] = (f == F_SHIFT) ? 5 : 0;
            for (int ch = 0; ch < 4; ch++) begin
                fa[f][ch] = {8'($urandom_range(0, PWM_FULL - 1)), 16'($urandom)};
                if (f == F_SHIFT)
                    fa[f][ch][15:0] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
            end
            if (f < 6) fa[f][0] = dir[f];
        end
        for (int f = 0; f < NF; f++) begin
            // shifted frame loses its last period and the frame result; reset frame keeps 8 periods
            nper = (f == F_SHIFT) ? 15 : (f == F_RST) ? 8 : 16;
            for (int p = 0; p < nper; p++) begin
                for (int ch = 0; ch < 4; ch++) pw[8*ch +: 8] = 8'(hi_of(fa[f][ch], p));
                per_q.push_back(pw);
            end
            if (nper == 16) begin
                for (int ch = 0; ch < 4; ch++)
                    fw[12*ch +: 12] = 12'(16 * int'(fa[f][ch][23:16]) + $countones(fa[f][ch][15:0]));
                frm_q.push_back(fw);
            end
        end
    endtask

    always @(negedge clk) begin
        if (per_vld) begin
            if (per_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL per_extra: per_vld_o with data %0h, expected no pulse", per_dat);
            end else begin
                check("per_dat", 64'(per_dat), 64'(per_q.pop_front()));
            end
        end
        if (frm_vld) begin
            check("frm_with_per", 64'(per_vld), 64'(1));
            if (frm_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL frm_extra: frm_vld_o with data %0h, expected no pulse", frm_dat);
            end else begin
                check("frm_dat", 64'(frm_dat), 64'(frm_q.pop_front()));
            end
        end
    end

    initial begin
        int tr;
        rstn = 1'b0;
        sync = 1'b0;
        clr  = 1'b0;
        pwm  = '0;
        build_plan();
        tr = s_of(F_RST) + DLY + 8 * PWM_FULL + 40;
        repeat (3) @(negedge clk);
        check("rst_per_dat", 64'(per_dat), 64'(0));
        check("rst_frm_dat", 64'(frm_dat), 64'(0));
        check("rst_per_vld", 64'(per_vld), 64'(0));
        check("rst_frm_vld", 64'(frm_vld), 64'(0));
        check("rst_locked", 64'(locked), 64'(0));
        check("rst_sync_err", 64'(sync_err), 64'(0));
        rstn = 1'b1;

        for (int t = 0; t < T_END; t++) begin
            @(negedge clk);
            if (t == s_of(0) + DLY)            check("locked_before_sev", 64'(locked), 64'(0));
            if (t == s_of(0) + DLY + 1)        check("locked_after_sev", 64'(locked), 64'(1));
            if (t == s_of(0) + DLY + FL)       check("first_frm_early", 64'(frm_vld), 64'(0));
            if (t == s_of(0) + DLY + FL + 1)   check("first_frm_latency", 64'(frm_vld), 64'(1));
            if (t == s_of(F_SHIFT))            check("err_before_shift", 64'(sync_err), 64'(0));
            if (t == s_of(F_SHIFT) + 20)       check("err_after_shift", 64'(sync_err), 64'(1));
            if (t == s_of(F_SHIFT + 1) + 100)  check("err_sticky", 64'(sync_err), 64'(1));
            if (t == s_of(F_SHIFT + 1) + 202)  check("err_cleared", 64'(sync_err), 64'(0));
            if (t == s_of(F_RST) + 100)        check("err_stays_clear", 64'(sync_err), 64'(0));
            if (t == s_of(F_RST + 1) + DLY)     check("hunt_after_reset", 64'(locked), 64'(0));
            if (t == s_of(F_RST + 1) + DLY + 1) begin
                check("relock_with_clr", 64'(locked), 64'(1));
                check("relock_no_err", 64'(sync_err), 64'(0));
            end

            sync = is_sync(t);
            pwm  = pins_at(t);
            clr  = (t == s_of(F_SHIFT + 1) + 200) || (t == s_of(F_RST + 1) + DLY);
            if (t == tr) begin
                rstn = 1'b0;
                #1;
                check("mid_rst_per_dat", 64'(per_dat), 64'(0));
                check("mid_rst_frm_dat", 64'(frm_dat), 64'(0));
                check("mid_rst_vld", 64'({per_vld, frm_vld}), 64'(0));
                check("mid_rst_locked", 64'(locked), 64'(0));
                check("mid_rst_sync_err", 64'(sync_err), 64'(0));
            end
            if (t == tr + 4) rstn = 1'b1;
        end

        @(negedge clk);
        check("per_q_drained", 64'(per_q.size()), 64'(0));
        check("frm_q_drained", 64'(frm_q.size()), 64'(0));
        check("end_locked", 64'(locked), 64'(1));
        check("end_sync_err", 64'(sync_err), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
